// File: rtl/comp_bist_pkg.sv
// Shared types, defaults and the golden-result function for the comparator BIST engine.
package comp_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_SETTLE = 1;

  // Unsigned compare; callers zero-extend their operands to 32 bits.
  function automatic logic [2:0] exp_gle(input logic [31:0] a, input logic [31:0] b);
    return {a > b, a < b, a == b};
  endfunction

endpackage

// File: rtl/comp_golden.sv
// Combinational reference comparator producing the expected G/L/E for the current vector.
module comp_golden
  import comp_bist_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             g,
  output logic             l,
  output logic             e
);

  logic [2:0] gle;

  assign gle       = exp_gle(32'(a), 32'(b));
  assign {g, l, e} = gle;

endmodule

// File: rtl/four_bit_comp_bist.sv
// Exhaustive stimulus/response BIST for a WIDTH-bit magnitude comparator.
// Optional first-failing-vector capture when COMP_BIST_FIRST_FAIL_EN is defined.
module four_bit_comp_bist
  import comp_bist_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   a_o,
  output logic [WIDTH-1:0]   b_o,
  input  logic               g_i,
  input  logic               l_i,
  input  logic               e_i,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_cnt
`ifdef COMP_BIST_FIRST_FAIL_EN
  ,
  output logic               first_fail_vld,
  output logic [WIDTH-1:0]   first_fail_a,
  output logic [WIDTH-1:0]   first_fail_b
`endif
);

  localparam int IW = 2 * WIDTH;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IW-1:0] IDX_MAX     = '1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  state_t          state;
  logic [IW-1:0]   idx;
  logic [SW-1:0]   settle_cnt;
  logic            exp_g;
  logic            exp_l;
  logic            exp_e;
  logic            vec_fail;

  comp_golden #(.WIDTH(WIDTH)) u_golden (
    .a (a_o),
    .b (b_o),
    .g (exp_g),
    .l (exp_l),
    .e (exp_e)
  );

  // Any differing bit fails the vector, including non-one-hot responses.
  assign vec_fail = ({g_i, l_i, e_i} != {exp_g, exp_l, exp_e});

  assign a_o  = idx[IW-1:WIDTH];
  assign b_o  = idx[WIDTH-1:0];
  assign pass = done && (err_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_cnt    <= '0;
`ifdef COMP_BIST_FIRST_FAIL_EN
      first_fail_vld <= 1'b0;
      first_fail_a   <= '0;
      first_fail_b   <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx        <= '0;
            settle_cnt <= '0;
            err_cnt    <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            state      <= APPLY;
`ifdef COMP_BIST_FIRST_FAIL_EN
            first_fail_vld <= 1'b0;
            first_fail_a   <= '0;
            first_fail_b   <= '0;
`endif
          end
        end
        APPLY: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (vec_fail) begin
            err_cnt <= err_cnt + 1'b1;
`ifdef COMP_BIST_FIRST_FAIL_EN
            if (!first_fail_vld) begin
              first_fail_vld <= 1'b1;
              first_fail_a   <= a_o;
              first_fail_b   <= b_o;
            end
`endif
          end
          settle_cnt <= '0;
          // Last vector ends the sweep; operands stay parked on it.
          if (idx == IDX_MAX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_four_bit_comp_bist.sv
// Bench for four_bit_comp_bist: behavioural comparator with injectable faults, two DUTs (SETTLE=1 and 3).
module tb_four_bit_comp_bist;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start3;
  logic [3:0] a1, b1, a3, b3;
  logic       g1, l1, e1, g3, l3, e3;
  logic       busy1, done1, pass1, busy3, done3, pass3;
  logic [8:0] err1, err3;
`ifdef COMP_BIST_FIRST_FAIL_EN
  logic       ffv1, ffv3;
  logic [3:0] ffa1, ffb1, ffa3, ffb3;
`endif

  // Attached comparator behaviour: a lookup indexed by {a,b}, rebuilt per fault mode.
  logic [2:0] resp_tab [256];
  logic [2:0] mask     [256];

  int n_cmp = 0;
  int n_err = 0;
  logic sel3 = 1'b0;

  always #5 clk = ~clk;

  assign {g1, l1, e1} = resp_tab[{a1, b1}];
  assign {g3, l3, e3} = resp_tab[{a3, b3}];

  four_bit_comp_bist #(.WIDTH(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_o(a1), .b_o(b1),
    .g_i(g1), .l_i(l1), .e_i(e1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1)
`ifdef COMP_BIST_FIRST_FAIL_EN
    , .first_fail_vld(ffv1), .first_fail_a(ffa1), .first_fail_b(ffb1)
`endif
  );

  four_bit_comp_bist #(.WIDTH(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a_o(a3), .b_o(b3),
    .g_i(g3), .l_i(l3), .e_i(e3), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err3)
`ifdef COMP_BIST_FIRST_FAIL_EN
    , .first_fail_vld(ffv3), .first_fail_a(ffa3), .first_fail_b(ffb3)
`endif
  );

  wire       busy_s = sel3 ? busy3 : busy1;
  wire       done_s = sel3 ? done3 : done1;
  wire       pass_s = sel3 ? pass3 : pass1;
  wire [8:0] err_s  = sel3 ? err3  : err1;
  wire [3:0] a_s    = sel3 ? a3    : a1;
  wire [3:0] b_s    = sel3 ? b3    : b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Modes: 0 correct, 1 E stuck at 0, 2 G/L swapped, 3 random bit flips.
  task automatic set_mode(input int m);
    for (int i = 0; i < 256; i++) begin
      int ia, ib;
      logic [2:0] ok;
      ia = i / 16;
      ib = i % 16;
      ok = {ia > ib, ia < ib, ia == ib};
      case (m)
        1:       resp_tab[i] = {ok[2], ok[1], 1'b0};
        2:       resp_tab[i] = {ok[1], ok[2], ok[0]};
        3:       resp_tab[i] = ok ^ mask[i];
        default: resp_tab[i] = ok;
      endcase
    end
  endtask

  // Reference: failures are the vectors whose response differs from the ideal comparison.
  function automatic int model_err();
    int n = 0;
    for (int i = 0; i < 256; i++)
      if (resp_tab[i] != {(i / 16) > (i % 16), (i / 16) < (i % 16), (i / 16) == (i % 16)}) n++;
    return n;
  endfunction

  function automatic int model_first();
    for (int i = 0; i < 256; i++)
      if (resp_tab[i] != {(i / 16) > (i % 16), (i / 16) < (i % 16), (i / 16) == (i % 16)}) return i;
    return 0;
  endfunction

  task automatic drive_start(input logic v);
    if (sel3) start3 = v; else start1 = v;
  endtask

  // Start a sweep, optionally re-pulse start mid-sweep, and count cycles until done.
  task automatic sweep(input logic s3, input int pulse_at, output int cyc);
    sel3 = s3;
    @(negedge clk);
    drive_start(1'b1);
    @(posedge clk);
    #1;
    drive_start(1'b0);
    check("busy_rise", busy_s, 1);
    check("done_clr", done_s, 0);
    check("a_first", a_s, 0);
    check("b_first", b_s, 0);
    cyc = 0;
    while (cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
      drive_start(cyc == pulse_at);
      if (done_s) break;
    end
    drive_start(1'b0);
    if (!done_s) check("sweep_timeout", 0, 1);
    check("busy_fall", busy_s, 0);
  endtask

  task automatic check_result(input string tag, input int cyc, input int exp_cyc);
    int ne;
    ne = model_err();
    check({tag, "_len"}, cyc, exp_cyc);
    check({tag, "_err"}, err_s, ne);
    check({tag, "_pass"}, pass_s, (ne == 0));
    check({tag, "_a_end"}, a_s, 4'hF);
    check({tag, "_b_end"}, b_s, 4'hF);
`ifdef COMP_BIST_FIRST_FAIL_EN
    check({tag, "_ffv"}, sel3 ? ffv3 : ffv1, (ne != 0));
    check({tag, "_ffa"}, sel3 ? ffa3 : ffa1, (ne != 0) ? model_first() / 16 : 0);
    check({tag, "_ffb"}, sel3 ? ffb3 : ffb1, (ne != 0) ? model_first() % 16 : 0);
`endif
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    for (int i = 0; i < 256; i++)
      mask[i] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    set_mode(0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_pass", pass1, 0);
    check("rst_err", err1, 0);
    check("rst_a", a1, 0);
    check("rst_b", b1, 0);

    set_mode(0);
    sweep(1'b0, -1, cyc);
    check_result("good", cyc, 512);

    set_mode(1);
    sweep(1'b0, -1, cyc);
    check_result("e_stuck", cyc, 512);

    set_mode(2);
    sweep(1'b0, 100, cyc);
    check_result("gl_swap_restart", cyc, 512);

    set_mode(0);
    sweep(1'b0, -1, cyc);
    check_result("rerun_clear", cyc, 512);

    set_mode(3);
    sweep(1'b0, -1, cyc);
    check_result("random_flips", cyc, 512);

    // Reset mid-sweep on a faulty comparator.
    set_mode(2);
    sel3 = 1'b0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check("mid_err_nonzero", (err1 != 0), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mrst_busy", busy1, 0);
    check("mrst_done", done1, 0);
    check("mrst_err", err1, 0);
    check("mrst_a", a1, 0);
    check("mrst_b", b1, 0);

    set_mode(0);
    sweep(1'b0, -1, cyc);
    check_result("after_rst", cyc, 512);

    set_mode(0);
    sweep(1'b1, -1, cyc);
    check_result("settle3", cyc, 1024);

    set_mode(3);
    sweep(1'b1, -1, cyc);
    check_result("settle3_rand", cyc, 1024);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
